// File: rtl/multi_register_file.sv
`default_nettype none
// ============================================================================
// Module   : multi_register_file
// Purpose  : Parametrised register file with parallel per-register
//            dec/inc/load/clear, sticky per-register overflow flags and two
//            independent combinational read ports (out-of-range reads give 0).
// Revision : 1.0 - initial release
// ============================================================================
module multi_register_file #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               SAT       = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SEL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             E,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [SEL_W-1:0] OutASel,
  input  logic [SEL_W-1:0] OutBSel,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [DEPTH-1:0] Ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [1:0]       FUN_DEC  = 2'b00;
  localparam logic [1:0]       FUN_INC  = 2'b01;
  localparam logic [1:0]       FUN_LOAD = 2'b10;
  localparam logic [1:0]       FUN_CLR  = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0][WIDTH-1:0] regs_next;
  logic [DEPTH-1:0]            ovf_flags;
  logic [DEPTH-1:0]            ovf_next;

  // Next value and flag for every register; each selected register acts on
  // its own current contents, so all selected registers update in parallel.
  always_comb begin
    regs_next = regs;
    ovf_next  = ovf_flags;
    for (int k = 0; k < DEPTH; k++) begin
      if (E && RegSel[k]) begin
        case (FunSel)
          FUN_CLR: begin
            // Clear goes to zero, not to RESET_VAL.
            regs_next[k] = '0;
            ovf_next[k]  = 1'b0;
          end
          FUN_LOAD: begin
            regs_next[k] = I;
            ovf_next[k]  = 1'b0;
          end
          FUN_INC: begin
            if (regs[k] == ALL_ONES) begin
              regs_next[k] = (SAT != 0) ? ALL_ONES : '0;
              ovf_next[k]  = 1'b1;
            end else begin
              regs_next[k] = regs[k] + WIDTH'(1);
            end
          end
          FUN_DEC: begin
            if (regs[k] == '0) begin
              regs_next[k] = (SAT != 0) ? '0 : ALL_ONES;
              ovf_next[k]  = 1'b1;
            end else begin
              regs_next[k] = regs[k] - WIDTH'(1);
            end
          end
          default: begin
            regs_next[k] = regs[k];
            ovf_next[k]  = ovf_flags[k];
          end
        endcase
      end
    end
  end

  // Register and flag storage with asynchronous reset to RESET_VAL / clear flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= RESET_VAL;
      end
      ovf_flags <= '0;
    end else begin
      regs      <= regs_next;
      ovf_flags <= ovf_next;
    end
  end

  // Read ports: compare against each valid index so indices >= DEPTH read 0.
  always_comb begin
    outA = '0;
    outB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OutASel == SEL_W'(k)) outA = regs[k];
      if (OutBSel == SEL_W'(k)) outB = regs[k];
    end
  end

  assign Ovf = ovf_flags;

endmodule
`default_nettype wire

// File: tb/tb_multi_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_register_file
// Purpose  : Self-checking bench for multi_register_file: a main 8x4 wrap
//            instance driven from a vector table, plus a 4-bit saturating
//            instance and a 3-deep instance for out-of-range reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_register_file;

  logic clock = 1'b0;
  logic reset;

  // Main instance: WIDTH=8, DEPTH=4, SAT=0, RESET_VAL=8'h5A
  logic       m_e;
  logic [7:0] m_i;
  logic [1:0] m_fs;
  logic [3:0] m_rs;
  logic [1:0] m_as, m_bs;
  logic [7:0] m_oa, m_ob;
  logic [3:0] m_ovf;

  // Saturating instance: WIDTH=4, DEPTH=4, SAT=1
  logic       s_e;
  logic [3:0] s_i;
  logic [1:0] s_fs;
  logic [3:0] s_rs;
  logic [1:0] s_as, s_bs;
  logic [3:0] s_oa, s_ob;
  logic [3:0] s_ovf;

  // Three-deep instance: WIDTH=8, DEPTH=3, RESET_VAL=8'h33
  logic       d_e;
  logic [7:0] d_i;
  logic [1:0] d_fs;
  logic [2:0] d_rs;
  logic [1:0] d_as, d_bs;
  logic [7:0] d_oa, d_ob;
  logic [2:0] d_ovf;

  multi_register_file #(.WIDTH(8), .DEPTH(4), .SAT(0), .RESET_VAL(8'h5A)) u_main (
    .clock(clock), .reset(reset), .E(m_e), .I(m_i), .FunSel(m_fs), .RegSel(m_rs),
    .OutASel(m_as), .OutBSel(m_bs), .outA(m_oa), .outB(m_ob), .Ovf(m_ovf));

  multi_register_file #(.WIDTH(4), .DEPTH(4), .SAT(1), .RESET_VAL(4'h0)) u_sat (
    .clock(clock), .reset(reset), .E(s_e), .I(s_i), .FunSel(s_fs), .RegSel(s_rs),
    .OutASel(s_as), .OutBSel(s_bs), .outA(s_oa), .outB(s_ob), .Ovf(s_ovf));

  multi_register_file #(.WIDTH(8), .DEPTH(3), .SAT(0), .RESET_VAL(8'h33)) u_d3 (
    .clock(clock), .reset(reset), .E(d_e), .I(d_i), .FunSel(d_fs), .RegSel(d_rs),
    .OutASel(d_as), .OutBSel(d_bs), .outA(d_oa), .outB(d_ob), .Ovf(d_ovf));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       e;
    logic [1:0] fs;
    logic [3:0] rs;
    logic [7:0] i;
    logic [1:0] as;
    logic [1:0] bs;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] eo;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // fs: 00 dec, 01 inc, 10 load, 11 clear. Starts from all 8'h5A, flags 0.
    vecs[0]  = '{1'b1, 2'b10, 4'b0101, 8'h80, 2'd0, 2'd2, 8'h80, 8'h80, 4'b0000};
    vecs[1]  = '{1'b0, 2'b10, 4'b0000, 8'h00, 2'd1, 2'd3, 8'h5A, 8'h5A, 4'b0000};
    vecs[2]  = '{1'b1, 2'b10, 4'b0010, 8'hFE, 2'd1, 2'd0, 8'hFE, 8'h80, 4'b0000};
    vecs[3]  = '{1'b1, 2'b01, 4'b0010, 8'h00, 2'd1, 2'd1, 8'hFF, 8'hFF, 4'b0000};
    vecs[4]  = '{1'b1, 2'b01, 4'b0010, 8'h00, 2'd1, 2'd1, 8'h00, 8'h00, 4'b0010};
    vecs[5]  = '{1'b1, 2'b01, 4'b0010, 8'h00, 2'd1, 2'd1, 8'h01, 8'h01, 4'b0010};
    vecs[6]  = '{1'b1, 2'b10, 4'b0010, 8'h10, 2'd1, 2'd1, 8'h10, 8'h10, 4'b0000};
    vecs[7]  = '{1'b1, 2'b00, 4'b1000, 8'h00, 2'd3, 2'd1, 8'h59, 8'h10, 4'b0000};
    vecs[8]  = '{1'b1, 2'b11, 4'b0001, 8'h00, 2'd0, 2'd2, 8'h00, 8'h80, 4'b0000};
    vecs[9]  = '{1'b1, 2'b00, 4'b0001, 8'h00, 2'd0, 2'd0, 8'hFF, 8'hFF, 4'b0001};
    vecs[10] = '{1'b0, 2'b11, 4'b1111, 8'h00, 2'd0, 2'd1, 8'hFF, 8'h10, 4'b0001};
    vecs[11] = '{1'b0, 2'b11, 4'b1111, 8'h00, 2'd2, 2'd3, 8'h80, 8'h59, 4'b0001};
    vecs[12] = '{1'b1, 2'b01, 4'b0000, 8'h00, 2'd0, 2'd3, 8'hFF, 8'h59, 4'b0001};
    vecs[13] = '{1'b1, 2'b11, 4'b1111, 8'h00, 2'd0, 2'd3, 8'h00, 8'h00, 4'b0000};
    vecs[14] = '{1'b1, 2'b01, 4'b1111, 8'h00, 2'd1, 2'd2, 8'h01, 8'h01, 4'b0000};
    vecs[15] = '{1'b1, 2'b10, 4'b0001, 8'hFF, 2'd0, 2'd1, 8'hFF, 8'h01, 4'b0000};
    vecs[16] = '{1'b1, 2'b01, 4'b0011, 8'h00, 2'd0, 2'd1, 8'h00, 8'h02, 4'b0001};

    // ---- Reset applied without any clock edge ----
    reset = 1'b1;
    m_e = 1'b0; m_i = '0; m_fs = 2'b00; m_rs = '0; m_as = 2'd0; m_bs = 2'd3;
    s_e = 1'b0; s_i = '0; s_fs = 2'b00; s_rs = '0; s_as = 2'd0; s_bs = 2'd0;
    d_e = 1'b0; d_i = '0; d_fs = 2'b00; d_rs = '0; d_as = 2'd3; d_bs = 2'd2;
    #2;
    chk("reset_outA", 32'(m_oa), 32'h5A);
    chk("reset_outB", 32'(m_ob), 32'h5A);
    chk("reset_ovf", 32'(m_ovf), 32'h0);
    chk("d3_reset_oob_outA", 32'(d_oa), 32'h0);
    chk("d3_reset_outB", 32'(d_ob), 32'h33);

    // Clock edges while reset is held have no effect
    m_e = 1'b1; m_fs = 2'b10; m_i = 8'hFF; m_rs = 4'b1111;
    tick();
    tick();
    chk("reset_hold_outA", 32'(m_oa), 32'h5A);
    chk("reset_hold_outB", 32'(m_ob), 32'h5A);
    chk("reset_hold_ovf", 32'(m_ovf), 32'h0);
    m_e = 1'b0;
    reset = 1'b0;

    // ---- Table-driven main sequence ----
    for (int k = 0; k < NV; k++) begin
      m_e = vecs[k].e; m_fs = vecs[k].fs; m_rs = vecs[k].rs; m_i = vecs[k].i;
      m_as = vecs[k].as; m_bs = vecs[k].bs;
      tick();
      chk($sformatf("vec%0d_outA", k), 32'(m_oa), 32'(vecs[k].ea));
      chk($sformatf("vec%0d_outB", k), 32'(m_ob), 32'(vecs[k].eb));
      chk($sformatf("vec%0d_ovf", k), 32'(m_ovf), 32'(vecs[k].eo));
    end

    // ---- No read-during-write bypass (R0 = 00, R1 = 02 here) ----
    m_e = 1'b1; m_fs = 2'b10; m_rs = 4'b0001; m_i = 8'hAA; m_as = 2'd0; m_bs = 2'd0;
    #1;
    chk("rdw_before_edge", 32'(m_oa), 32'h00);
    tick();
    chk("rdw_after_edge", 32'(m_ob), 32'hAA);
    m_e = 1'b0;

    // ---- Combinational read latency: change selector only ----
    m_as = 2'd1;
    #1;
    chk("comb_read_outA", 32'(m_oa), 32'h02);

    // ---- Saturating instance ----
    s_e = 1'b1; s_rs = 4'b0001; s_as = 2'd0; s_bs = 2'd1;
    s_fs = 2'b11; tick();
    chk("sat_clear", 32'(s_oa), 32'h0);
    s_fs = 2'b00; tick();
    chk("sat_dec_floor", 32'(s_oa), 32'h0);
    chk("sat_dec_ovf", 32'(s_ovf), 32'b0001);
    s_fs = 2'b10; s_i = 4'hF; tick();
    chk("sat_load_ovf_clr", 32'(s_ovf), 32'b0000);
    s_fs = 2'b01; tick();
    chk("sat_inc_ceiling", 32'(s_oa), 32'hF);
    chk("sat_inc_ovf", 32'(s_ovf), 32'b0001);
    s_fs = 2'b00; tick();
    chk("sat_dec_normal", 32'(s_oa), 32'hE);
    chk("sat_other_reg", 32'(s_ob), 32'h0);
    s_e = 1'b0;

    // ---- Three-deep instance: out-of-range read port ----
    d_e = 1'b1; d_fs = 2'b10; d_rs = 3'b100; d_i = 8'hC3;
    tick();
    d_e = 1'b0;
    chk("d3_oob_outA", 32'(d_oa), 32'h0);
    chk("d3_outB_r2", 32'(d_ob), 32'hC3);
    d_as = 2'd0;
    #1;
    chk("d3_outA_r0", 32'(d_oa), 32'h33);

    // ---- Asynchronous reset mid-sequence, away from any edge ----
    #2;
    reset = 1'b1;
    #1;
    m_as = 2'd0; m_bs = 2'd1;
    #1;
    chk("async_reset_outA", 32'(m_oa), 32'h5A);
    chk("async_reset_outB", 32'(m_ob), 32'h5A);
    chk("async_reset_ovf", 32'(m_ovf), 32'h0);
    chk("async_reset_sat", 32'(s_oa), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // First update after reset deasserts
    m_e = 1'b1; m_fs = 2'b01; m_rs = 4'b0001;
    tick();
    m_e = 1'b0;
    chk("post_reset_inc", 32'(m_oa), 32'h5B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
